// File: rtl/sram_ctrl_pkg.sv
// Shared types and default sizes for the SRAM port controller.
package sram_ctrl_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_e;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_NUM_WMASKS = DEF_DATA_WIDTH / 8;
    localparam int DEF_RSP_DEPTH  = 4;

endpackage

// File: rtl/sram_port_ctrl_fifo.sv
// Synchronous response FIFO with occupancy count and reset flush.
// Head entry is shown on rdata_o; an empty FIFO presents zero.
module sram_rsp_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_pop;

    // Explicit wrap so the pointer also works for a single-entry FIFO
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; push and pop in one cycle cancel in the count
    always_comb begin
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push_i && do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Control state; reset flushes all entries
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Data storage needs no reset; empty entries are never shown
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // The upstream credit rule must never push into a full FIFO without a pop
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_i && !do_pop) begin
            assert (cnt_q != CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/sram_port_ctrl.sv
// Request-side controller for the 1RW port of the 32x256 SRAM macro.
// Zero-fills the array after reset, then turns a valid/ready request
// stream into registered macro strobes and returns read data in order.
module sram_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_WMASKS = DEF_NUM_WMASKS,
    parameter int RSP_DEPTH  = DEF_RSP_DEPTH,
    parameter int INIT_ZERO  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    ctrl_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic                  init_done_q, init_done_d;
    logic [1:0]            rd_pipe_q, rd_pipe_d;   // [0] issued, [1] sampled by macro
    logic                  csb_q, csb_d;
    logic                  web_q, web_d;
    logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;

    logic [CNT_W-1:0]      fifo_cnt;
    logic                  fifo_empty;
    logic [SUM_W-1:0]      credits_used;
    logic                  req_acc;
    logic                  rsp_pop;

    // Every read in the pipe already owns a FIFO slot, so ready depends
    // only on registered state. init_done_q keeps ready low on the first
    // cycle out of reset when the zero-fill is skipped.
    assign credits_used = SUM_W'(fifo_cnt) + SUM_W'(rd_pipe_q[0]) + SUM_W'(rd_pipe_q[1]);
    assign req_ready    = (state_q == RUN) && init_done_q &&
                          (credits_used < SUM_W'(RSP_DEPTH));
    assign req_acc      = req_valid && req_ready;
    assign rsp_valid    = !fifo_empty;
    assign rsp_pop      = rsp_valid && rsp_ready;

    assign init_done    = init_done_q;
    assign sram_csb0    = csb_q;
    assign sram_web0    = web_q;
    assign sram_wmask0  = wmask_q;
    assign sram_addr0   = addr_q;
    assign sram_din0    = din_q;

    sram_rsp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (rd_pipe_q[1]),
        .wdata_i (sram_dout0),
        .pop_i   (rsp_pop),
        .rdata_o (rsp_rdata),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // Next-state: zero-fill sweep in INIT, request issue in RUN, idle strobes otherwise
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        csb_d       = 1'b1;
        web_d       = 1'b1;
        wmask_d     = '0;
        addr_d      = addr_q;
        din_d       = din_q;
        rd_pipe_d   = {rd_pipe_q[0], 1'b0};

        if (state_q == INIT) begin
            csb_d      = 1'b0;
            web_d      = 1'b0;
            wmask_d    = '1;
            addr_d     = init_cnt_q;
            din_d      = '0;
            init_cnt_d = init_cnt_q + 1'b1;
            if (&init_cnt_q) begin
                state_d     = RUN;
                init_done_d = 1'b1;
            end
        end else begin
            init_done_d = 1'b1;
            if (req_acc) begin
                csb_d        = 1'b0;
                web_d        = !req_we;
                wmask_d      = req_we ? req_wmask : '0;
                addr_d       = req_addr;
                din_d        = req_we ? req_wdata : '0;
                rd_pipe_d[0] = !req_we;
            end
        end
    end

    // State and macro-facing registers; reset drops in-flight reads
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= (INIT_ZERO != 0) ? INIT : RUN;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            rd_pipe_q   <= '0;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            wmask_q     <= '0;
            addr_q      <= '0;
            din_q       <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            rd_pipe_q   <= rd_pipe_d;
            csb_q       <= csb_d;
            web_q       <= web_d;
            wmask_q     <= wmask_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
        end
    end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: behavioural 1RW macro on clk0=clk, a word-array
// reference memory with an in-order expected-response queue, directed
// cases for init/latency/backpressure/reset, then random traffic.
module tb_sram_port_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int NM    = 4;
    localparam int RD    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [NM-1:0] req_wmask = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic          sram_csb0;
    logic          sram_web0;
    logic [NM-1:0] sram_wmask0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic [DW-1:0] sram_dout0 = '0;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] expq [$];
    int            rd_cyc [$];
    int            rsp_cyc [$];

    // Macro model state
    logic [DW-1:0] mac_mem [DEPTH];
    logic          m_csb = 1'b1;
    logic          m_web = 1'b1;
    logic [NM-1:0] m_wmask = '0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_din = '0;

    sram_port_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_WMASKS (NM),
        .RSP_DEPTH  (RD),
        .INIT_ZERO  (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wmask   (req_wmask),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .init_done   (init_done),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_dout0  (sram_dout0)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] d,
                                            input logic [NM-1:0] m);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < NM; b++) if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Macro: latch port at posedge, write or read at the following negedge
    initial for (int i = 0; i < DEPTH; i++) mac_mem[i] = $urandom;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        m_csb   <= sram_csb0;
        m_web   <= sram_web0;
        m_wmask <= sram_wmask0;
        m_addr  <= sram_addr0;
        m_din   <= sram_din0;
    end

    always @(negedge clk) begin
        if (!m_csb && !m_web) mac_mem[m_addr] <= merge(mac_mem[m_addr], m_din, m_wmask);
        if (!m_csb && m_web)  sram_dout0 <= mac_mem[m_addr];
    end

    // Reference model: memory updated at acceptance, reads answered in order
    always @(posedge clk) begin
        if (rst) begin
            expq.delete();
            for (int i = 0; i < DEPTH; i++) ref_mem[i] <= '0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                rsp_cyc.push_back(cyc);
                chk("rsp_expected", 64'(expq.size() > 0), 64'd1);
                if (expq.size() > 0) chk("rsp_data", 64'(rsp_rdata), 64'(expq.pop_front()));
            end
            if (req_valid && req_ready) begin
                if (req_we) begin
                    ref_mem[req_addr] <= merge(ref_mem[req_addr], req_wdata, req_wmask);
                end else begin
                    expq.push_back(ref_mem[req_addr]);
                    rd_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic send(input logic we, input logic [AW-1:0] a,
                        input logic [NM-1:0] m, input logic [DW-1:0] d);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wmask = m;
        req_wdata = d;
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("send_timeout", 64'(n >= 2000), 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Read with rsp_valid timing: low after E and E+1, high after E+2
    task automatic read_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        rsp_ready = 1'b1;
        send(1'b0, a, '0, '0);
        chk({tag, "_v_e0"}, 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_v_e1"}, 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_v_e2"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_data"}, 64'(rsp_rdata), 64'(exp));
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        while ((expq.size() != 0 || rsp_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(expq.size()), 64'd0);
    endtask

    // Called right after reset is released at a negedge: edge k writes addr k-1
    task automatic init_walk();
        for (int k = 1; k <= DEPTH; k++) begin
            @(negedge clk);
            chk("init_addr", 64'(sram_addr0), 64'(k - 1));
            chk("init_ctl", 64'({sram_csb0, sram_web0, sram_wmask0, rsp_valid}), 64'(7'b00_1111_0));
            chk("init_din", 64'(sram_din0), 64'd0);
            chk("init_done", 64'(init_done), 64'(k == DEPTH));
            chk("init_ready", 64'(req_ready), 64'(k == DEPTH));
        end
        @(negedge clk);
        chk("run_idle_csb", 64'(sram_csb0), 64'd1);
    endtask

    initial begin
        int idx;
        logic acc;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_strobes", 64'({sram_csb0, sram_web0, sram_wmask0}), 64'(6'b11_0000));
        chk("rst_addr", 64'(sram_addr0), 64'd0);
        chk("rst_din", 64'(sram_din0), 64'd0);
        rst = 1'b0;
        init_walk();

        // Zero-fill reached the top address
        read_chk("rd_ff", 8'hFF, 32'h0);
        drain("drain_ff");

        // Read directly behind a write to the same word
        send(1'b1, 8'h10, 4'hF, 32'hDEADBEEF);
        read_chk("raw_10", 8'h10, 32'hDEADBEEF);
        drain("drain_10");

        // Partial byte-lane write
        send(1'b1, 8'h20, 4'hF, 32'h11223344);
        send(1'b1, 8'h20, 4'b0101, 32'hAABBCCDD);
        read_chk("mask_20", 8'h20, 32'h11BB33DD);
        drain("drain_20");

        // Zero mask write leaves the word alone
        send(1'b1, 8'h20, 4'h0, 32'h55555555);
        read_chk("mask0_20", 8'h20, 32'h11BB33DD);
        drain("drain_m0");

        // Backpressure: six reads against four credits
        for (int i = 0; i < 6; i++) send(1'b1, AW'(8'h40 + i), 4'hF, 32'h1000 + i);
        rsp_ready = 1'b0;
        idx = 0;
        req_we = 1'b0;
        req_wmask = '0;
        req_wdata = '0;
        for (int c = 0; c < 12; c++) begin
            req_valid = (idx < 6);
            req_addr  = AW'(8'h40 + idx);
            acc = req_valid && req_ready;
            @(negedge clk);
            if (acc) idx++;
        end
        chk("bp_accepts", 64'(idx), 64'd4);
        chk("bp_ready_low", 64'(req_ready), 64'd0);
        chk("bp_held", 64'(expq.size()), 64'd4);
        rsp_ready = 1'b1;
        for (int c = 0; c < 40 && idx < 6; c++) begin
            req_valid = 1'b1;
            req_addr  = AW'(8'h40 + idx);
            acc = req_ready;
            @(negedge clk);
            if (acc) idx++;
        end
        req_valid = 1'b0;
        chk("bp_all", 64'(idx), 64'd6);
        drain("drain_bp");

        // Back-to-back reads 0..7, one per cycle, responses with no bubbles
        for (int i = 0; i < 8; i++) send(1'b1, AW'(i), 4'hF, $urandom);
        rd_cyc.delete();
        rsp_cyc.delete();
        for (int i = 0; i < 8; i++) send(1'b0, AW'(i), '0, '0);
        drain("drain_b2b");
        chk("b2b_reads", 64'(rd_cyc.size()), 64'd8);
        chk("b2b_rsps", 64'(rsp_cyc.size()), 64'd8);
        if (rd_cyc.size() == 8 && rsp_cyc.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("b2b_issue_gap", 64'(rd_cyc[i] - rd_cyc[0]), 64'(i));
                // valid visible after E+2, consumed at edge E+3
                chk("b2b_rsp_lat", 64'(rsp_cyc[i] - rd_cyc[i]), 64'd3);
            end
        end

        // Reset at INIT cycle 100 restarts the sweep from address 0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("mid_init_addr", 64'(sram_addr0), 64'd99);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_csb", 64'(sram_csb0), 64'd1);
        chk("mid_rst_done", 64'(init_done), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        rst = 1'b0;
        init_walk();

        // Reset with two reads in flight discards them
        send(1'b1, 8'h05, 4'hF, 32'hCAFE0005);
        send(1'b0, 8'h05, '0, '0);
        send(1'b0, 8'h05, '0, '0);
        rst = 1'b1;
        @(negedge clk);
        chk("flush_csb", 64'(sram_csb0), 64'd1);
        chk("flush_valid", 64'(rsp_valid), 64'd0);
        chk("flush_rdata", 64'(rsp_rdata), 64'd0);
        rst = 1'b0;
        init_walk();
        read_chk("post_flush_05", 8'h05, 32'h0);
        drain("drain_flush");

        // Random traffic on a small address window for frequent hazards
        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom_range(0, 9) < 6);
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = AW'($urandom_range(0, 15));
            req_wmask = NM'($urandom);
            req_wdata = $urandom;
            rsp_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
        end
        drain("drain_rand");
        chk("rand_no_valid", 64'(rsp_valid), 64'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
